// File: rtl/itch_feed_arbiter.sv
// Round-robin arbiter sharing one ITCH byte-stream parser between N_FEEDS feeds,
// granting whole length-framed messages. Optional per-feed counters: ARB_MSG_COUNT_EN.
module itch_feed_arbiter #(
   parameter  int N_FEEDS = 4,
   localparam int FEED_W  = $clog2(N_FEEDS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*N_FEEDS-1:0]   feed_byte,
   input  logic [N_FEEDS-1:0]     feed_valid,
   output logic [N_FEEDS-1:0]     feed_ready,
   output logic [7:0]             out_byte,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FEED_W-1:0]      out_feed_id,
   output logic                   out_last,
   output logic                   busy,
   output logic                   len_zero_err,
   output logic [32*N_FEEDS-1:0]  msg_count
);

   typedef enum logic {IDLE, FWD} state_t;

   state_t              state_q, state_d;
   logic [FEED_W-1:0]   grant_q;
   logic [FEED_W-1:0]   rr_ptr_q;
   logic [FEED_W-1:0]   pick;
   logic [FEED_W-1:0]   rr_next;
   logic                any_valid;
   int unsigned         cand;
   logic [1:0]          hdr_q;
   logic [7:0]          len_hi_q;
   logic [15:0]         remaining_q;
   logic [7:0]          cur_byte;
   logic                cur_valid;
   logic                can_load;
   logic                accept;
   logic                is_last;

   // First valid feed at or after rr_ptr, wrapping.
   always_comb begin
      pick      = '0;
      any_valid = 1'b0;
      cand      = 0;
      for (int unsigned i = 0; i < N_FEEDS; i++) begin
         cand = (32'(rr_ptr_q) + i) % 32'(N_FEEDS);
         if (!any_valid && feed_valid[FEED_W'(cand)]) begin
            any_valid = 1'b1;
            pick      = FEED_W'(cand);
         end
      end
   end

   assign cur_byte  = feed_byte[8*grant_q +: 8];
   assign cur_valid = feed_valid[grant_q];
   assign can_load  = !out_valid || out_ready;
   assign accept    = (state_q == FWD) && cur_valid && can_load;
   assign is_last   = ((hdr_q == 2'd1) && ({len_hi_q, cur_byte} == 16'd0)) ||
                      ((hdr_q == 2'd2) && (remaining_q == 16'd1));
   assign rr_next   = (grant_q == FEED_W'(N_FEEDS - 1)) ? '0 : grant_q + 1'b1;
   assign busy      = (state_q == FWD);

   always_comb begin
      feed_ready = '0;
      if (state_q == FWD) feed_ready[grant_q] = can_load;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = FWD;
         FWD:     if (accept && is_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         hdr_q        <= '0;
         len_hi_q     <= '0;
         remaining_q  <= '0;
         out_byte     <= '0;
         out_valid    <= 1'b0;
         out_feed_id  <= '0;
         out_last     <= 1'b0;
         len_zero_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_zero_err <= 1'b0;
         if (accept) begin
            out_byte    <= cur_byte;
            out_feed_id <= grant_q;
            out_valid   <= 1'b1;
            out_last    <= is_last;
         end else if (out_ready) begin
            out_valid   <= 1'b0;
         end
         if (state_q == IDLE) begin
            if (any_valid) begin
               grant_q <= pick;
               hdr_q   <= '0;
            end
         end else if (accept) begin
            case (hdr_q)
               2'd0: begin
                  len_hi_q <= cur_byte;
                  hdr_q    <= 2'd1;
               end
               2'd1: begin
                  remaining_q  <= {len_hi_q, cur_byte};
                  hdr_q        <= 2'd2;
                  len_zero_err <= ({len_hi_q, cur_byte} == 16'd0);
               end
               default: remaining_q <= remaining_q - 16'd1;
            endcase
            if (is_last) rr_ptr_q <= rr_next;
         end
      end
   end

`ifdef ARB_MSG_COUNT_EN
   logic [32*N_FEEDS-1:0] msg_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_count_q <= '0;
      end else if (accept && is_last) begin
         msg_count_q[32*grant_q +: 32] <= msg_count_q[32*grant_q +: 32] + 32'd1;
      end
   end

   assign msg_count = msg_count_q;
`else
   assign msg_count = '0;
`endif

endmodule
